alu_result_fifo: RTL

- Buffer stage directly downstream of the 16-bit bitwise logic units (XNOR and siblings).
- Captures each result word with its opcode tag, computes status flags at capture, and queues the entries in a small FIFO for the ALU writeback and display logic.
- Uses valid/ready handshakes on both sides, so a stalled consumer never loses a result.

---
 rtl/alu_result_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Result buffer behind the 16-bit logic units: captures {op, flags, data} and queues them in a small FIFO.
// Optional push counter / sticky stall flag when ALU_RESULT_FIFO_STATS_EN is defined.
module alu_result_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned OPW   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [OPW-1:0]           in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [OPW-1:0]           out_op,
   output logic                     out_zero,
   output logic                     out_ones,
   output logic                     out_parity,
   output logic [$clog2(DEPTH):0]   level
`ifdef ALU_RESULT_FIFO_STATS_EN
   ,
   output logic [15:0]              stat_count,
   output logic                     stat_stall
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = OPW + 3 + WIDTH;
   localparam logic [PW:0]   FULL_LVL = DEPTH[PW:0];
   localparam logic [PW:0]   LVL_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   logic [EW-1:0]  mem_q [DEPTH];
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW:0]    level_q, level_d;
   logic           full, empty, push, pop;
   logic [EW-1:0]  wr_entry, head;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign push  = in_valid && !full;
   assign pop   = out_ready && !empty;

   // Flags are frozen at capture time so the consumer sees exactly what the logic unit produced.
   assign wr_entry = {in_op, (in_data == '0), (&in_data), (^in_data), in_data};

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Stale storage is masked while empty, so reset never has to touch the array.
   assign head = empty ? '0 : mem_q[rd_ptr_q];
   assign {out_op, out_zero, out_ones, out_parity, out_data} = head;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign level     = level_q;

`ifdef ALU_RESULT_FIFO_STATS_EN
   logic [15:0] stat_count_q, stat_count_d;
   logic        stat_stall_q, stat_stall_d;

   always_comb begin
      stat_count_d = stat_count_q;
      stat_stall_d = stat_stall_q;
      if (push)                 stat_count_d = stat_count_q + 16'd1;
      if (in_valid && full)     stat_stall_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_count_q <= '0;
         stat_stall_q <= 1'b0;
      end else begin
         stat_count_q <= stat_count_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_count = stat_count_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule
